// File: rtl/rr_arbiter_burst_lock_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiter.
//   arb_state_e    : arbiter state encoding (IDLE = no owner, BUSY = owner locked)
//   onehot_to_idx(): converts a one-hot vector (up to 32 bits) to its bit index
package rr_arbiter_burst_lock_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // OR-reduction of the indices of set bits. For a true one-hot input this is
    // the position of the single set bit. An all-zero input returns 0.
    function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_burst_lock_if.sv
// Request/grant bundle between requesters and the burst-locking arbiter.
//   req       : per-requester request, held for the whole burst
//   req_last  : per-requester "current beat is the last one"
//   xfer      : shared resource accepted a beat from the current owner
//   gnt       : registered one-hot grant
//   gnt_id    : index of the owner (meaningful only while gnt_valid)
//   gnt_valid : registered, equals |gnt
//   preempt   : single-cycle pulse when a burst is cut at the beat cap
// Modports: master = requester/resource side, slave = arbiter side.
interface rr_arbiter_burst_lock_if #(
    parameter int SIZE = 4
) ();
    localparam int IDW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [SIZE-1:0] req;
    logic [SIZE-1:0] req_last;
    logic            xfer;
    logic [SIZE-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_valid;
    logic            preempt;

    modport master (
        output req, req_last, xfer,
        input  gnt, gnt_id, gnt_valid, preempt
    );

    modport slave (
        input  req, req_last, xfer,
        output gnt, gnt_id, gnt_valid, preempt
    );

endinterface

// File: rtl/rr_arbiter_burst_lock_prio.sv
// Combinational fixed-priority arbiter: the lowest set bit of req wins.
//   req : request vector
//   gnt : one-hot grant (all zero when req is all zero)
module prio_arbiter_lsb_first #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] req,
    output logic [SIZE-1:0] gnt
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + SIZE'(1));

endmodule

// File: rtl/rr_arbiter_burst_lock.sv
// Round-robin arbiter that locks the grant to one requester for a whole burst.
// A burst ends on the owner's last beat, when the owner drops its request, or
// when MAX_BEATS beats have been accepted (forced release, flagged by preempt).
// After every release the grant is zero for one cycle and the round-robin
// pointer moves to the requester just after the previous owner.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : rr_arbiter_burst_lock_if slave modport (req/req_last/xfer in,
//         gnt/gnt_id/gnt_valid/preempt out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ARB_IDLE | no owner; pick a winner from req starting at ptr
// ARB_BUSY | owner locked; grant held until last beat, beat cap or abandon
module rr_arbiter_burst_lock
    import rr_arbiter_burst_lock_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int MAX_BEATS = 16
) (
    input logic                   clk,
    input logic                   rst,
    rr_arbiter_burst_lock_if.slave bus
);

    localparam int IDW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CW  = $clog2(MAX_BEATS + 1);

    localparam logic [0:0]     ST_IDLE  = 1'(ARB_IDLE);
    localparam logic [0:0]     ST_BUSY  = 1'(ARB_BUSY);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_BEATS - 1);
    localparam logic [IDW-1:0] IDX_LAST = IDW'(SIZE - 1);

    logic [0:0]      state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  owner_q;
    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] gnt_q;
    logic            gnt_valid_q;
    logic            preempt_q;

    logic [SIZE-1:0] mask;
    logic [SIZE-1:0] req_masked;
    logic [SIZE-1:0] oh_masked;
    logic [SIZE-1:0] oh_unmasked;
    logic [SIZE-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  ptr_next;

    logic own_req;
    logic own_last;
    logic rel_last;
    logic rel_cap;
    logic rel_drop;

    // Keep requesters at or above ptr; equivalent to req & ~((1<<ptr)-1).
    always_comb begin
        mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            mask[i] = (IDW'(i) >= ptr_q);
        end
    end

    assign req_masked = bus.req & mask;

    prio_arbiter_lsb_first #(.SIZE(SIZE)) u_prio_masked (
        .req (req_masked),
        .gnt (oh_masked)
    );

    prio_arbiter_lsb_first #(.SIZE(SIZE)) u_prio_unmasked (
        .req (bus.req),
        .gnt (oh_unmasked)
    );

    // Nobody at or above ptr: wrap around and take the lowest requester.
    assign win_oh  = (|oh_masked) ? oh_masked : oh_unmasked;
    assign win_idx = IDW'(onehot_to_idx(32'(win_oh)));

    assign own_req  = bus.req[owner_q];
    assign own_last = bus.req_last[owner_q];

    // Release priority: last beat, then beat cap, then abandon.
    assign rel_last = bus.xfer && own_last;
    assign rel_cap  = bus.xfer && !own_last && (cnt_q == CNT_MAX);
    assign rel_drop = !own_req;

    assign ptr_next = (owner_q == IDX_LAST) ? '0 : owner_q + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q       <= win_oh;
                        gnt_valid_q <= 1'b1;
                        owner_q     <= win_idx;
                        cnt_q       <= '0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (rel_last || rel_cap || rel_drop) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        ptr_q       <= ptr_next;
                        preempt_q   <= rel_cap;
                        state_q     <= ST_IDLE;
                    end else if (bus.xfer) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = owner_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_burst_lock.sv
// Directed bench for rr_arbiter_burst_lock. Two instances share the stimulus:
// dut_a uses MAX_BEATS=16 (handshake, fairness, lock, abandon, wrap, reset),
// dut_b uses MAX_BEATS=4 (forced release). Each stimulus cycle pushes the
// hand-computed outputs expected after the next rising edge; a monitor pops
// one entry per cycle and compares it against the selected instance.
module tb_rr_arbiter_burst_lock;

    localparam int SIZE = 4;

    typedef struct {
        logic [3:0] g;
        logic       p;
        logic       use_b;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic       xfer = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q[$];

    always #5 clk = ~clk;

    rr_arbiter_burst_lock_if #(.SIZE(SIZE)) ifa ();
    rr_arbiter_burst_lock_if #(.SIZE(SIZE)) ifb ();

    assign ifa.req      = req;
    assign ifa.req_last = last;
    assign ifa.xfer     = xfer;
    assign ifb.req      = req;
    assign ifb.req_last = last;
    assign ifb.xfer     = xfer;

    rr_arbiter_burst_lock #(.SIZE(SIZE), .MAX_BEATS(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    rr_arbiter_burst_lock #(.SIZE(SIZE), .MAX_BEATS(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic cyc(input logic r_rst, input logic [3:0] r, input logic [3:0] l,
                       input logic x, input logic [3:0] eg, input logic ep,
                       input logic use_b, input string name);
        exp_t e;
        @(negedge clk);
        rst  = r_rst;
        req  = r;
        last = l;
        xfer = x;
        e.g = eg;
        e.p = ep;
        e.use_b = use_b;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t       e;
        logic [3:0] ag;
        logic [1:0] aid;
        logic       av;
        logic       ap;
        logic [1:0] eid;
        logic       ok;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                ag  = e.use_b ? ifb.gnt       : ifa.gnt;
                aid = e.use_b ? ifb.gnt_id    : ifa.gnt_id;
                av  = e.use_b ? ifb.gnt_valid : ifa.gnt_valid;
                ap  = e.use_b ? ifb.preempt   : ifa.preempt;
                eid = 2'd0;
                for (int i = 0; i < 4; i++) if (e.g[i]) eid = 2'(i);
                ok = (ag == e.g) && (av == (|e.g)) && (ap == e.p) &&
                     ((e.g == 4'b0000) || (aid == eid));
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b id=%0d valid=%b preempt=%b, want gnt=%b id=%0d valid=%b preempt=%b",
                             e.name, ag, aid, av, ap, e.g, eid, |e.g, e.p);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        // reset
        cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, "reset0");
        cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, "reset1");
        cyc(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, "idle_xfer_ignored");

        // basic handshake
        cyc(0, 4'b1010, 4'b0000, 0, 4'b0010, 0, 0, "first_grant");
        cyc(0, 4'b1010, 4'b0010, 1, 4'b0000, 0, 0, "last_release");
        cyc(0, 4'b1010, 4'b0000, 0, 4'b1000, 0, 0, "next_grant_3");
        cyc(0, 4'b1010, 4'b1000, 1, 4'b0000, 0, 0, "release_3");
        cyc(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, "idle_no_req");

        // fairness with single-beat bursts
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, "rr_0");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, "rr_dead0");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0010, 0, 0, "rr_1");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, "rr_dead1");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0100, 0, 0, "rr_2");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, "rr_dead2");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b1000, 0, 0, "rr_3");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, "rr_dead3");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, "rr_0_again");
        cyc(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, "rr_dead4");
        cyc(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, "rr_idle");

        // lock: owner 2, 5-beat burst while everyone requests
        cyc(0, 4'b0100, 4'b0000, 0, 4'b0100, 0, 0, "lock_grant");
        cyc(0, 4'b1111, 4'b1011, 1, 4'b0100, 0, 0, "lock_beat1");
        cyc(0, 4'b1111, 4'b1011, 1, 4'b0100, 0, 0, "lock_beat2");
        cyc(0, 4'b1111, 4'b0100, 0, 4'b0100, 0, 0, "lock_last_no_xfer");
        cyc(0, 4'b1111, 4'b1011, 1, 4'b0100, 0, 0, "lock_beat3");
        cyc(0, 4'b1111, 4'b0000, 1, 4'b0100, 0, 0, "lock_beat4");
        cyc(0, 4'b1111, 4'b0100, 1, 4'b0000, 0, 0, "lock_beat5_last");
        cyc(0, 4'b1111, 4'b0000, 0, 4'b1000, 0, 0, "lock_next_3");

        // wrap: owner 3 releases, ptr wraps to 0
        cyc(0, 4'b1001, 4'b1000, 1, 4'b0000, 0, 0, "wrap_release");
        cyc(0, 4'b1001, 4'b0000, 0, 4'b0001, 0, 0, "wrap_grant_0");

        // abandon without and with xfer
        cyc(0, 4'b1001, 4'b0000, 0, 4'b0001, 0, 0, "abandon_hold");
        cyc(0, 4'b1000, 4'b0000, 0, 4'b0000, 0, 0, "abandon_drop");
        cyc(0, 4'b1001, 4'b0000, 0, 4'b1000, 0, 0, "abandon_ptr_adv");
        cyc(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, "abandon_with_xfer");
        cyc(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, "abandon_wrap_grant");

        // reset mid-burst
        cyc(0, 4'b1111, 4'b0001, 1, 4'b0000, 0, 0, "pre_rst_release");
        cyc(0, 4'b1111, 4'b0000, 0, 4'b0010, 0, 0, "pre_rst_grant1");
        cyc(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, "rst_busy");
        cyc(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 0, "rst_ptr_zero");
        cyc(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, "rst_after_drop");

        // forced release on dut_b (MAX_BEATS=4)
        cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, "b_reset");
        cyc(0, 4'b0101, 4'b0000, 0, 4'b0001, 0, 1, "b_grant0");
        cyc(0, 4'b0101, 4'b0000, 1, 4'b0001, 0, 1, "b_beat1");
        cyc(0, 4'b0101, 4'b0000, 1, 4'b0001, 0, 1, "b_beat2");
        cyc(0, 4'b0101, 4'b0000, 1, 4'b0001, 0, 1, "b_beat3");
        cyc(0, 4'b0101, 4'b0000, 1, 4'b0000, 1, 1, "b_beat4_preempt");
        cyc(0, 4'b0101, 4'b0000, 0, 4'b0100, 0, 1, "b_next_owner2");
        cyc(0, 4'b0101, 4'b0000, 1, 4'b0100, 0, 1, "b2_beat1");
        cyc(0, 4'b0101, 4'b0000, 1, 4'b0100, 0, 1, "b2_beat2");
        cyc(0, 4'b0101, 4'b0000, 1, 4'b0100, 0, 1, "b2_beat3");
        cyc(0, 4'b0101, 4'b0100, 1, 4'b0000, 0, 1, "b2_beat4_last_no_preempt");
        cyc(0, 4'b0101, 4'b0000, 0, 4'b0001, 0, 1, "b_wrap_grant0");

        @(negedge clk);
        req  = '0;
        last = '0;
        xfer = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
